// File: rtl/serial_tx.sv
// 8N1 UART transmitter with a 4-entry byte FIFO on a valid/ready input.
// tx is taken straight from a flop; the bit timer restarts on every bit boundary.
module serial_tx #(
    parameter int unsigned CLKRATE  = 12_000_000,
    parameter int unsigned BAUDRATE = 9600
) (
    input  logic       osc,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned Div  = CLKRATE / BAUDRATE;
    localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] TimerMax = CntW'(Div - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [4];
    logic [1:0]      wptr_q, wptr_d;
    logic [1:0]      rptr_q, rptr_d;
    logic [2:0]      count_q, count_d;

    logic            push;
    logic            pop;
    logic            tick;
    logic            fifo_nempty;

    assign ready       = (count_q != 3'd4);
    assign push        = valid && ready;
    assign fifo_nempty = (count_q != 3'd0);
    assign tick        = (timer_q == TimerMax);
    assign tx          = tx_q;
    assign busy        = (state_q != StIdle) || fifo_nempty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 2'd1;
        end
        if (pop) begin
            rptr_d = rptr_q + 2'd1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        if (state_q != StIdle) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        // Next bit is shift_q[1] because the register shifts this same edge.
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge osc) begin
        if (push) begin
            mem_q[wptr_q] <= data;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at DIV=16: reset, single frames, burst, push/pop overlap, idle.
module tb_serial_tx;

    logic       osc;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    int tests;
    int fails;

    serial_tx #(
        .CLKRATE (16),
        .BAUDRATE(1)
    ) dut (
        .osc  (osc),
        .rst_n(rst_n),
        .data (data),
        .valid(valid),
        .ready(ready),
        .tx   (tx),
        .busy (busy)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    task automatic step();
        @(posedge osc);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called just after the edge that starts bit 0 (or skip cycles later); returns just
    // after the edge that ends the stop bit. Optionally pushes a byte on that final edge.
    task automatic frame(input logic [7:0] b, input string tag, input int skip,
                         input logic push_en, input logic [7:0] push_byte);
        logic e;
        int   off;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) e = 1'b0;
            else if (k == 9) e = 1'b1;
            else e = b[k-1];
            off = (k == 0) ? skip : 0;
            if (off == 0) check($sformatf("%s bit%0d first", tag, k), tx, e);
            repeat (15 - off) step();
            check($sformatf("%s bit%0d last", tag, k), tx, e);
            check($sformatf("%s bit%0d busy", tag, k), busy, 1'b1);
            if (k == 9 && push_en) begin
                data  = push_byte;
                valid = 1'b1;
                step();
                valid = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    task automatic send_one(input logic [7:0] b, input string tag);
        data  = b;
        valid = 1'b1;
        step();
        valid = 1'b0;
        check({tag, " accepted busy"}, busy, 1'b1);
        check({tag, " accepted tx"}, tx, 1'b1);
        check({tag, " accepted ready"}, ready, 1'b1);
        step();
        frame(b, tag, 0, 1'b0, 8'h00);
        check({tag, " end busy"}, busy, 1'b0);
        check({tag, " end tx"}, tx, 1'b1);
    endtask

    logic [7:0] sb [7];

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        data  = 8'h00;
        valid = 1'b0;
        sb = '{8'h3C, 8'h81, 8'h5A, 8'hC3, 8'h7E, 8'h99, 8'h24};

        repeat (3) step();
        check("reset tx", tx, 1'b1);
        check("reset ready", ready, 1'b1);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) step();
        check("post reset tx", tx, 1'b1);
        check("post reset busy", busy, 1'b0);

        send_one(8'hA5, "a5");
        repeat (4) step();
        send_one(8'h00, "x00");
        repeat (4) step();
        send_one(8'hFF, "xff");
        repeat (4) step();

        // Burst: first pop coincides with the second push, so five pushes fill the FIFO.
        for (int i = 1; i <= 5; i++) begin
            data  = 8'(i);
            valid = 1'b1;
            check($sformatf("burst ready push%0d", i), ready, 1'b1);
            step();
        end
        valid = 1'b0;
        check("burst full ready", ready, 1'b0);
        frame(8'h01, "burst1", 3, 1'b0, 8'h00);
        check("burst ready back", ready, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            frame(8'(i), $sformatf("burst%0d", i), 0, 1'b0, 8'h00);
        end
        check("burst end busy", busy, 1'b0);
        check("burst end tx", tx, 1'b1);
        repeat (4) step();

        // Each frame boundary pops one byte while a new one is pushed in the same cycle.
        data  = sb[0];
        valid = 1'b1;
        step();
        data  = sb[1];
        step();
        valid = 1'b0;
        check("overlap start tx", tx, 1'b0);
        for (int i = 0; i < 7; i++) begin
            frame(sb[i], $sformatf("ovl%0d", i), 0, (i <= 4), (i <= 4) ? sb[i+2] : 8'h00);
            check($sformatf("ovl%0d ready", i), ready, 1'b1);
        end
        check("overlap end busy", busy, 1'b0);
        repeat (4) step();

        // Mid-frame reset with a byte still queued.
        data  = 8'h00;
        valid = 1'b1;
        step();
        step();
        valid = 1'b0;
        check("midrst start tx", tx, 1'b0);
        check("midrst busy before", busy, 1'b1);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst async tx", tx, 1'b1);
        check("midrst async busy", busy, 1'b0);
        check("midrst async ready", ready, 1'b1);
        #1 rst_n = 1'b1;
        repeat (3) step();
        check("midrst after tx", tx, 1'b1);
        check("midrst after busy", busy, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            step();
            check("idle tx", tx, 1'b1);
            check("idle busy", busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
